// File: rtl/ssp_rx_port.sv
// ---------------------------------------------------------------------------
// ssp_rx_port
//
// Receive half of a synchronous serial port. The serial clock, frame sync and
// data lines are treated as plain data in the pclk domain: they are
// synchronized, the rising edge of the serial clock is detected, and an
// IDLE/SHIFT state machine assembles MSB-first bytes. Each completed byte is
// pushed into a 4-entry circular FIFO that the host drains through a simple
// parallel read port.
//
// Ports
//   pclk       in   sole clock, rising edge
//   clear      in   synchronous active-high reset, wins over every event
//   psel       in   parallel port select
//   pwrite     in   1 = write cycle (no effect here), 0 = read cycle
//   sspclkin   in   serial receive clock (sampled, not used as a clock)
//   sspfssin   in   frame sync, one serial bit period wide, before the MSB
//   ssprxd     in   serial receive data, MSB first
//   prdata     out  [7:0] registered read data, holds between reads
//   ssprxintr  out  high while the FIFO is full
//   rxempty    out  high while the FIFO is empty
//   rxovr      out  sticky overrun flag, cleared only by clear
// ---------------------------------------------------------------------------
module ssp_rx_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       pclk,
  input  logic       clear,
  input  logic       psel,
  input  logic       pwrite,
  input  logic       sspclkin,
  input  logic       sspfssin,
  input  logic       ssprxd,
  output logic [7:0] prdata,
  output logic       ssprxintr,
  output logic       rxempty,
  output logic       rxovr
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = 2;
  localparam int CNT_W  = 3;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // synchronizer flops
  logic clk_s1_q, clk_s1_d;
  logic clk_s2_q, clk_s2_d;
  logic clk_s3_q, clk_s3_d;
  logic fss_s1_q, fss_s1_d;
  logic fss_s2_q, fss_s2_d;
  logic rxd_s1_q, rxd_s1_d;
  logic rxd_s2_q, rxd_s2_d;

  // receive state machine
  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] push_byte_q, push_byte_d;

  // FIFO and read port
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              rxovr_q, rxovr_d;

  logic sample;
  logic fifo_empty;
  logic fifo_full;
  logic rd_en;
  logic wr_en;

  // ---- stage: input synchronizers and serial clock edge detect ----
  always_comb begin
    clk_s1_d = sspclkin;
    clk_s2_d = clk_s1_q;
    clk_s3_d = clk_s2_q;
    fss_s1_d = sspfssin;
    fss_s2_d = fss_s1_q;
    rxd_s1_d = ssprxd;
    rxd_s2_d = rxd_s1_q;
  end

  // Rising edge of the synchronized serial clock; frame and data are taken
  // from the second synchronizer stage in this same cycle so all three lines
  // see identical latency.
  assign sample = clk_s2_q & ~clk_s3_q;

  // ---- stage: frame detection and byte assembly ----
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;

    case (state_q)
      ST_IDLE: begin
        // The frame sync bit itself carries no data; only arm the shifter.
        if (sample && fss_s2_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 3'd0;
        end
      end

      ST_SHIFT: begin
        if (sample) begin
          shreg_d   = {shreg_q[DATA_W-2:0], rxd_s2_q};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            // Last bit: hand the full byte to the FIFO one cycle later.
            push_d      = 1'b1;
            push_byte_d = {shreg_q[DATA_W-2:0], rxd_s2_q};
            bit_cnt_d   = 3'd0;
            // Frame sync coinciding with the last bit opens the next frame
            // without an idle gap.
            state_d     = fss_s2_q ? ST_SHIFT : ST_IDLE;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // ---- stage: FIFO push/pop and read port ----
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);

  // A read is qualified with the registered empty flag, so a push landing in
  // the same cycle into an empty FIFO is never read through.
  assign rd_en = psel & ~pwrite & ~fifo_empty;
  // When full, a push is only accepted if a read frees the head slot in the
  // same cycle (write and read pointers coincide; the read sees the old head).
  assign wr_en = push_q & (~fifo_full | rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    prdata_d = prdata_q;
    rxovr_d  = rxovr_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = push_byte_q;
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end

    if (rd_en) begin
      prdata_d = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 2'd1;
    end

    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    // Byte dropped: full, no room made this cycle.
    if (push_q && fifo_full && !rd_en) begin
      rxovr_d = 1'b1;
    end
  end

  // ---- state registers ----
  always_ff @(posedge pclk) begin
    if (clear) begin
      clk_s1_q    <= 1'b0;
      clk_s2_q    <= 1'b0;
      clk_s3_q    <= 1'b0;
      fss_s1_q    <= 1'b0;
      fss_s2_q    <= 1'b0;
      rxd_s1_q    <= 1'b0;
      rxd_s2_q    <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      prdata_q    <= '0;
      rxovr_q     <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_s3_q    <= clk_s3_d;
      fss_s1_q    <= fss_s1_d;
      fss_s2_q    <= fss_s2_d;
      rxd_s1_q    <= rxd_s1_d;
      rxd_s2_q    <= rxd_s2_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      prdata_q    <= prdata_d;
      rxovr_q     <= rxovr_d;
    end
  end

  // FIFO storage is never observed before being written, so it needs no reset.
  always_ff @(posedge pclk) begin
    mem_q <= mem_d;
  end

  assign prdata    = prdata_q;
  assign rxovr     = rxovr_q;
  assign ssprxintr = fifo_full;
  assign rxempty   = fifo_empty;

endmodule

// File: tb/tb_ssp_rx_port.sv
// ---------------------------------------------------------------------------
// tb_ssp_rx_port
//
// Drives serial frames (serial clock period = 8 pclk periods) and parallel
// reads into ssp_rx_port, and compares the flags and read data against a
// byte-queue reference model of the receive FIFO.
// ---------------------------------------------------------------------------
module tb_ssp_rx_port;

  logic       pclk = 1'b0;
  logic       clear;
  logic       psel;
  logic       pwrite;
  logic       sspclkin;
  logic       sspfssin;
  logic       ssprxd;
  logic [7:0] prdata;
  logic       ssprxintr;
  logic       rxempty;
  logic       rxovr;

  always #5 pclk = ~pclk;

  ssp_rx_port #(.FIFO_DEPTH(4)) dut (
    .pclk      (pclk),
    .clear     (clear),
    .psel      (psel),
    .pwrite    (pwrite),
    .sspclkin  (sspclkin),
    .sspfssin  (sspfssin),
    .ssprxd    (ssprxd),
    .prdata    (prdata),
    .ssprxintr (ssprxintr),
    .rxempty   (rxempty),
    .rxovr     (rxovr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bytes waiting in the FIFO, sticky overrun, last read.
  logic [7:0] ref_q[$];
  logic       ref_ovr    = 1'b0;
  logic [7:0] ref_prdata = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_frame(input logic [7:0] b);
    if (ref_q.size() < 4) ref_q.push_back(b);
    else ref_ovr = 1'b1;
  endfunction

  function automatic void ref_read();
    if (ref_q.size() > 0) ref_prdata = ref_q.pop_front();
  endfunction

  function automatic void ref_clear();
    ref_q.delete();
    ref_ovr    = 1'b0;
    ref_prdata = 8'h00;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_rxempty"}, 32'(rxempty), 32'(ref_q.size() == 0));
    chk({tag, "_intr"}, 32'(ssprxintr), 32'(ref_q.size() == 4));
    chk({tag, "_rxovr"}, 32'(rxovr), 32'(ref_ovr));
    chk({tag, "_prdata"}, 32'(prdata), 32'(ref_prdata));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      psel   = 1'b0;
      pwrite = 1'b0;
    end
  endtask

  // One serial bit: 4 pclk low (data/frame change), 4 pclk high. With rd set,
  // a one-cycle read is placed so the FIFO sees it on the same pclk edge as
  // the push caused by this bit's rising edge (2 sync stages + 1 FSM cycle).
  task automatic send_bit(input logic fss, input logic d, input bit rd);
    @(negedge pclk);
    psel     = 1'b0;
    pwrite   = 1'b0;
    sspclkin = 1'b0;
    sspfssin = fss;
    ssprxd   = d;
    repeat (3) @(negedge pclk);
    @(negedge pclk);
    sspclkin = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge pclk);
      if (rd && i == 3) begin
        psel   = 1'b1;
        pwrite = 1'b0;
      end
    end
  endtask

  // Eight data bits MSB first; fss_last asserts frame sync on the last bit
  // (back-to-back frame follows).
  task automatic send_byte(input logic [7:0] b, input bit fss_last, input bit rd_last);
    for (int i = 7; i >= 0; i--) begin
      send_bit((i == 0) ? fss_last : 1'b0, b[i], (i == 0) ? rd_last : 1'b0);
    end
    if (rd_last) ref_read();
    ref_frame(b);
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_bit(1'b1, 1'($urandom), 1'b0);
    send_byte(b, 1'b0, 1'b0);
    idle(3);
  endtask

  task automatic do_read();
    @(negedge pclk);
    psel   = 1'b1;
    pwrite = 1'b0;
    @(negedge pclk);
    psel   = 1'b0;
    ref_read();
  endtask

  task automatic do_write_cycle();
    @(negedge pclk);
    psel   = 1'b1;
    pwrite = 1'b1;
    @(negedge pclk);
    psel   = 1'b0;
    pwrite = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge pclk);
    clear = 1'b1;
    @(negedge pclk);
    clear = 1'b0;
    ref_clear();
  endtask

  logic [7:0] b2b [4] = '{8'hAA, 8'hF0, 8'h55, 8'h0F};
  logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    clear    = 1'b1;
    psel     = 1'b0;
    pwrite   = 1'b0;
    sspclkin = 1'b0;
    sspfssin = 1'b0;
    ssprxd   = 1'b0;
    repeat (3) @(negedge pclk);
    clear = 1'b0;
    ref_clear();
    check_state("reset");

    // single frame then read
    send_frame(8'hA5);
    check_state("a5_rx");
    do_read();
    check_state("a5_rd");

    // back-to-back frames fill the FIFO
    send_bit(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(b2b[k], (k < 3), 1'b0);
    idle(3);
    check_state("b2b_full");
    for (int k = 0; k < 4; k++) begin
      do_read();
      check_state("b2b_rd");
    end

    // overrun: fifth byte dropped, sticky flag
    for (int k = 0; k < 4; k++) send_frame(fill[k]);
    check_state("ovr_fill");
    send_frame(8'hFF);
    check_state("ovr_set");
    for (int k = 0; k < 4; k++) begin
      do_read();
      check_state("ovr_rd");
    end
    idle(5);
    check_state("ovr_sticky");
    pulse_clear();
    check_state("ovr_clear");

    // read in the same cycle as a push into a full FIFO
    for (int k = 0; k < 4; k++) send_frame(fill[k] ^ 8'h80);
    send_bit(1'b1, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b1);
    idle(3);
    check_state("full_rdpush");
    for (int k = 0; k < 4; k++) begin
      do_read();
      check_state("full_rdpush_rd");
    end

    // read on empty keeps prdata; write cycles never pop
    do_read();
    check_state("empty_rd");
    send_frame(8'h9E);
    repeat (3) do_write_cycle();
    check_state("wr_nopop");
    do_read();
    check_state("wr_nopop_rd");

    // clear in the middle of a frame
    send_frame(8'h5A);
    do_read();
    send_frame(8'h77);
    check_state("pre_abort");
    send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 7; i >= 3; i--) send_bit(1'b0, 1'((8'hD3 >> i) & 1), 1'b0);
    @(negedge pclk);
    sspclkin = 1'b0;
    idle(2);
    pulse_clear();
    check_state("abort_clear");
    send_frame(8'h81);
    check_state("abort_rx");
    do_read();
    check_state("abort_rd");

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0, 1: send_frame(8'($urandom));
        2: begin
          send_bit(1'b1, 1'($urandom), 1'b0);
          send_byte(8'($urandom), 1'b1, 1'b0);
          send_byte(8'($urandom), 1'b0, 1'b0);
          idle(3);
        end
        3: do_read();
        default: do_write_cycle();
      endcase
      check_state("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ssp_rx_port.md
SSP_RX_PORT -- requirements
Module: ssp_rx_port

Interface
REQ-001 SHALL have port: pclk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: clear  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: psel  input  1  chip select for the parallel read port.
REQ-004 SHALL have port: pwrite  input  1  1 = write cycle (ignored by this block), 0 = read cycle.
REQ-005 SHALL have port: sspclkin  input  1  serial receive clock, sampled as data in the pclk domain.
REQ-006 SHALL have port: sspfssin  input  1  receive frame sync, one sspclkin period wide, immediately before the MSB.
REQ-007 SHALL have port: ssprxd  input  1  serial receive data, MSB first.
REQ-008 SHALL have port: prdata  output  8  received byte, registered.
REQ-009 SHALL have port: ssprxintr  output  1  receive interrupt, high while the FIFO holds 4 entries.
REQ-010 SHALL have port: rxempty  output  1  high while the FIFO holds 0 entries.
REQ-011 SHALL have port: rxovr  output  1  sticky overrun flag.
REQ-012 SHALL have parameter: FIFO_DEPTH, default 4, receive FIFO entries (fixed at 4 for this release).

Function
REQ-013 SHALL pass sspclkin, sspfssin and ssprxd through a 2-flop synchronizer (s1, s2), plus a third flop on the clock path (s3).
REQ-014 SHALL define a sample event as s2_clk=1 and s3_clk=0; frame and data values are taken from s2 in that cycle.
REQ-015 SHALL require sspclkin high and low for at least 2 pclk cycles each; narrower pulses are out of scope.
REQ-016 SHALL implement the FSM states IDLE and SHIFT.
REQ-017 In IDLE, a sample event with frame=1 SHALL enter SHIFT with bit count 0; a sample event with frame=0 SHALL be ignored.
REQ-018 In SHIFT, each sample event SHALL shift data into the LSB of an 8-bit shift register and increment the 3-bit bit count.
REQ-019 On the 8th sample event in SHIFT, the assembled byte SHALL be pushed into the FIFO in the next pclk cycle.
REQ-020 On that 8th sample event, frame=1 SHALL start a back-to-back frame (stay in SHIFT, count 0); otherwise the FSM SHALL return to IDLE.
REQ-021 In SHIFT, frame=1 on sample events 1..7 SHALL be ignored.
REQ-022 The FIFO SHALL be 4 x 8 circular, with 2-bit read/write pointers wrapping 3->0 and a 3-bit occupancy count 0..4.
REQ-023 A read SHALL be psel=1, pwrite=0 and rxempty=0, sampled in the same cycle.
REQ-024 On a read, prdata SHALL load the head entry on the next edge and the read pointer SHALL advance: 1-cycle latency.
REQ-025 A read attempt while empty SHALL leave prdata and the pointers unchanged.
REQ-026 prdata SHALL hold its last value between reads.
REQ-027 A push while full with no read in the same cycle SHALL drop the byte, leave the FIFO unchanged and set rxovr.
REQ-028 rxovr SHALL stay high until clear.
REQ-029 A push and a read in the same cycle while full SHALL both occur, leaving the count at 4 and rxovr unchanged.
REQ-030 A push and a read in the same cycle while empty SHALL perform the push only.
REQ-031 ssprxintr SHALL equal (count==4) and rxempty SHALL equal (count==0), both decoded from registered state.
REQ-032 When psel=0, the block SHALL still receive and push serial frames; only reads are blocked.

Reset
REQ-033 clear=1 at a pclk edge SHALL set the FSM to IDLE and reset the bit count, pointers and occupancy count to 0.
REQ-034 That same reset SHALL also set the shift register, prdata and all synchronizer flops to 0, rxovr=0, ssprxintr=0 and rxempty=1.
REQ-035 clear SHALL take priority over all events in the same cycle.
REQ-036 A frame in progress when clear asserts SHALL be discarded.
REQ-037 After clear deasserts, reception SHALL restart only on the next frame=1 sample event.

Verification
REQ-038 Send frame 0xA5 (pclk period 10, sspclkin period 80) -> rxempty falls, count 1; read -> prdata=0xA5 one cycle later, rxempty=1.
REQ-039 Send back-to-back frames 0xAA, 0xF0, 0x55, 0x0F -> ssprxintr=1 after the 4th push; 4 reads return them in order, then rxempty=1 and ssprxintr=0.
REQ-040 Fill to 4 entries, then send 0xFF -> rxovr=1, FIFO contents unchanged, and the 4 reads return the original bytes.
REQ-041 Full FIFO: read in the same cycle as the push of 0x3C -> count stays 4, rxovr=0, and 0x3C is read last.
REQ-042 Assert clear after the 5th bit of a frame -> rxempty=1 and prdata=0x00; the next full frame 0x81 is received correctly.
REQ-043 Read with psel=1, pwrite=0 on an empty FIFO -> prdata unchanged; pwrite=1 cycles -> no pop.
